// File: rtl/pipe_pkg.sv
// Shared encodings for the MIPS pipeline hazard unit: forwarding selects,
// divider FSM states and default register-address width.
package pipe_pkg;

   localparam int REG_AW_DEF = 5;
   localparam int DIV_CNT_W  = 6;

   // Decode-stage operand select (branch comparator)
   localparam logic [1:0] FWD_D_RF = 2'b00;
   localparam logic [1:0] FWD_D_E  = 2'b01;
   localparam logic [1:0] FWD_D_M  = 2'b10;
   localparam logic [1:0] FWD_D_W  = 2'b11;

   // Execute-stage operand select (ALU)
   localparam logic [1:0] FWD_E_RF = 2'b00;
   localparam logic [1:0] FWD_E_W  = 2'b01;
   localparam logic [1:0] FWD_E_M  = 2'b10;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_BUSY = 2'b01,
      DIV_DONE = 2'b10
   } div_state_e;

endpackage

// File: rtl/haz_div_fsm.sv
// Fixed-latency divider handshake: start pulse, busy count, one-cycle done.
module haz_div_fsm
   import pipe_pkg::*;
#(
   parameter int DIV_CYCLES = 32
) (
   input  logic clk,
   input  logic resetn,
   input  logic divE,
   input  logic d_stallM,
   input  logic excM,
   output logic divstall,
   output logic div_startE,
   output logic div_doneE
);

   localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(DIV_CYCLES - 1);

   div_state_e           state_q, state_d;
   logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
   logic                 start_s;

   // Next-state and counter update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      start_s = 1'b0;
      case (state_q)
         DIV_IDLE: begin
            if (divE && !d_stallM && !excM) begin
               start_s = 1'b1;
               state_d = DIV_BUSY;
               cnt_d   = {DIV_CNT_W{1'b0}};
            end else begin
               state_d = DIV_IDLE;
            end
         end
         DIV_BUSY: begin
            if (excM) begin
               state_d = DIV_IDLE;
               cnt_d   = {DIV_CNT_W{1'b0}};
            end else if (cnt_q == CNT_LAST) begin
               state_d = DIV_DONE;
               cnt_d   = {DIV_CNT_W{1'b0}};
            end else begin
               cnt_d   = cnt_q + {{(DIV_CNT_W-1){1'b0}}, 1'b1};
            end
         end
         DIV_DONE: begin
            state_d = DIV_IDLE;
         end
         default: begin
            state_d = DIV_IDLE;
            cnt_d   = {DIV_CNT_W{1'b0}};
         end
      endcase
   end

   // FSM state and busy counter
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= DIV_IDLE;
         cnt_q   <= {DIV_CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The divide stays parked in E until the DONE cycle, when E advances
   always_comb begin
      div_startE = resetn & start_s;
      div_doneE  = resetn & (state_q == DIV_DONE);
      divstall   = resetn & (((state_q == DIV_IDLE) & divE) | (state_q == DIV_BUSY));
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall/flush control for the five-stage MIPS core.
// Build option HAZ_FWD_E2D_EN enables forwarding of the E-stage result to D.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int REG_AW     = REG_AW_DEF,
   parameter int DIV_CYCLES = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [REG_AW-1:0] rsD,
   input  logic [REG_AW-1:0] rtD,
   input  logic              branchD,
   input  logic              jrD,
   input  logic [REG_AW-1:0] rsE,
   input  logic [REG_AW-1:0] rtE,
   input  logic [REG_AW-1:0] writeregE,
   input  logic              regwriteE,
   input  logic              memtoregE,
   input  logic              divE,
   input  logic [REG_AW-1:0] writeregM,
   input  logic [REG_AW-1:0] writeregW,
   input  logic              regwriteM,
   input  logic              memtoregM,
   input  logic              regwriteW,
   input  logic              i_stallF,
   input  logic              d_stallM,
   input  logic              excM,
   output logic [1:0]        forwardaD,
   output logic [1:0]        forwardbD,
   output logic [1:0]        forwardaE,
   output logic [1:0]        forwardbE,
   output logic              stallF,
   output logic              stallD,
   output logic              stallE,
   output logic              stallM,
   output logic              flushD,
   output logic              flushE,
   output logic              flushM,
   output logic              flushW,
   output logic              div_startE,
   output logic              div_doneE,
   output logic              pc_exc_selF
);

`ifdef HAZ_FWD_E2D_EN
   localparam logic E2D_EN = 1'b1;
`else
   localparam logic E2D_EN = 1'b0;
`endif

   logic divstall;
   logic lu_d;
   logic br_d;
   logic src_hit_e;
   logic src_hit_m;
   logic exc_pend_q, exc_pend_d;

   // $zero is hard-wired, so it never counts as a producer/consumer match
   function automatic logic reg_hit(input logic [REG_AW-1:0] src,
                                    input logic [REG_AW-1:0] dst,
                                    input logic              wen);
      return wen && (src != {REG_AW{1'b0}}) && (src == dst);
   endfunction

   function automatic logic [1:0] sel_fwd_d(input logic [REG_AW-1:0] src,
                                            input logic [REG_AW-1:0] e_dst,
                                            input logic              e_wen,
                                            input logic [REG_AW-1:0] m_dst,
                                            input logic              m_wen,
                                            input logic [REG_AW-1:0] w_dst,
                                            input logic              w_wen);
      if (reg_hit(src, e_dst, e_wen)) begin
         return FWD_D_E;
      end else if (reg_hit(src, m_dst, m_wen)) begin
         return FWD_D_M;
      end else if (reg_hit(src, w_dst, w_wen)) begin
         return FWD_D_W;
      end else begin
         return FWD_D_RF;
      end
   endfunction

   function automatic logic [1:0] sel_fwd_e(input logic [REG_AW-1:0] src,
                                            input logic [REG_AW-1:0] m_dst,
                                            input logic              m_wen,
                                            input logic [REG_AW-1:0] w_dst,
                                            input logic              w_wen);
      if (reg_hit(src, m_dst, m_wen)) begin
         return FWD_E_M;
      end else if (reg_hit(src, w_dst, w_wen)) begin
         return FWD_E_W;
      end else begin
         return FWD_E_RF;
      end
   endfunction

   haz_div_fsm #(
      .DIV_CYCLES (DIV_CYCLES)
   ) u_div_fsm (
      .clk        (clk),
      .resetn     (resetn),
      .divE       (divE),
      .d_stallM   (d_stallM),
      .excM       (excM),
      .divstall   (divstall),
      .div_startE (div_startE),
      .div_doneE  (div_doneE)
   );

   // Operand forwarding, nearest producer first
   always_comb begin
      if (resetn) begin
         forwardaD = sel_fwd_d(rsD, writeregE, regwriteE & E2D_EN, writeregM, regwriteM,
                               writeregW, regwriteW);
         forwardbD = sel_fwd_d(rtD, writeregE, regwriteE & E2D_EN, writeregM, regwriteM,
                               writeregW, regwriteW);
         forwardaE = sel_fwd_e(rsE, writeregM, regwriteM, writeregW, regwriteW);
         forwardbE = sel_fwd_e(rtE, writeregM, regwriteM, writeregW, regwriteW);
      end else begin
         forwardaD = FWD_D_RF;
         forwardbD = FWD_D_RF;
         forwardaE = FWD_E_RF;
         forwardbE = FWD_E_RF;
      end
   end

   // Load-use and branch-operand hazards; load-use keys on writeregE, not rtE
   always_comb begin
      src_hit_e = reg_hit(rsD, writeregE, 1'b1) | reg_hit(rtD, writeregE, 1'b1);
      src_hit_m = reg_hit(rsD, writeregM, 1'b1) | reg_hit(rtD, writeregM, 1'b1);
      lu_d      = memtoregE & src_hit_e;
      br_d      = (branchD | jrD) &
                  ((memtoregE & src_hit_e) | (memtoregM & src_hit_m) |
                   (~E2D_EN & regwriteE & src_hit_e));
   end

   // An exception taken during a fetch stall waits for the fetch to finish
   always_comb begin
      if (i_stallF) begin
         exc_pend_d = exc_pend_q | excM;
      end else begin
         exc_pend_d = 1'b0;
      end
      pc_exc_selF = resetn & (excM | exc_pend_q) & ~i_stallF;
   end

   // Exception-pending flag
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         exc_pend_q <= 1'b0;
      end else begin
         exc_pend_q <= exc_pend_d;
      end
   end

   // Stall/flush priority: exception, data stall, divide, D hazard, fetch stall
   always_comb begin
      {stallF, stallD, stallE, stallM} = 4'b0000;
      {flushD, flushE, flushM, flushW} = 4'b0000;
      if (!resetn) begin
         {stallF, stallD, stallE, stallM} = 4'b0000;
      end else if (excM) begin
         {flushD, flushE, flushM, flushW} = 4'b1111;
         stallF = i_stallF;
      end else if (d_stallM) begin
         {stallF, stallD, stallE, stallM} = 4'b1111;
         flushW = 1'b1;
      end else if (divstall) begin
         {stallF, stallD, stallE} = 3'b111;
         flushM = 1'b1;
      end else if (lu_d || br_d) begin
         {stallF, stallD} = 2'b11;
         flushE = 1'b1;
      end else if (i_stallF) begin
         stallF = 1'b1;
         flushD = 1'b1;
      end else begin
         flushD = 1'b0;
      end
      if (resetn && exc_pend_q && i_stallF) begin
         stallF = 1'b1;
         flushD = 1'b1;
      end else begin
         stallM = stallM;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: random and directed stimulus against
// a behavioural model of the hazard rules; HAZ_FWD_E2D_EN follows the build.
module tb_pipe_hazard_ctrl;

   localparam int AW   = 5;
   localparam int NDIV = 4;
   localparam int NCYC = 3000;

`ifdef HAZ_FWD_E2D_EN
   localparam bit E2D = 1'b1;
`else
   localparam bit E2D = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          resetn;
   logic [AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
   logic          branchD, jrD, regwriteE, memtoregE, divE;
   logic          regwriteM, memtoregM, regwriteW, i_stallF, d_stallM, excM;
   logic [1:0]    forwardaD, forwardbD, forwardaE, forwardbE;
   logic          stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW;
   logic          div_startE, div_doneE, pc_exc_selF;

   typedef struct packed {
      logic [1:0] fad, fbd, fae, fbe;
      logic [3:0] stall;   // F D E M
      logic [3:0] flush;   // D E M W
      logic       start, done, pcsel;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   div_phase = -1;   // -1 free, 1..NDIV busy cycles, NDIV+1 done cycle
   bit   pend = 1'b0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.REG_AW(AW), .DIV_CYCLES(NDIV)) dut (
      .clk(clk), .resetn(resetn), .rsD(rsD), .rtD(rtD), .branchD(branchD), .jrD(jrD),
      .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
      .memtoregE(memtoregE), .divE(divE), .writeregM(writeregM), .writeregW(writeregW),
      .regwriteM(regwriteM), .memtoregM(memtoregM), .regwriteW(regwriteW),
      .i_stallF(i_stallF), .d_stallM(d_stallM), .excM(excM),
      .forwardaD(forwardaD), .forwardbD(forwardbD), .forwardaE(forwardaE),
      .forwardbE(forwardbE), .stallF(stallF), .stallD(stallD), .stallE(stallE),
      .stallM(stallM), .flushD(flushD), .flushE(flushE), .flushM(flushM),
      .flushW(flushW), .div_startE(div_startE), .div_doneE(div_doneE),
      .pc_exc_selF(pc_exc_selF)
   );

   function automatic logic [1:0] near_d(input logic [AW-1:0] src);
      logic [AW-1:0] dst[3];
      logic          wen[3];
      logic [1:0]    code[3];
      dst  = '{writeregE, writeregM, writeregW};
      wen  = '{regwriteE & E2D, regwriteM, regwriteW};
      code = '{2'b01, 2'b10, 2'b11};
      for (int i = 0; i < 3; i++)
         if (src != 0 && wen[i] && dst[i] == src) return code[i];
      return 2'b00;
   endfunction

   function automatic logic [1:0] near_e(input logic [AW-1:0] src);
      if (src != 0 && regwriteM && writeregM == src) return 2'b10;
      if (src != 0 && regwriteW && writeregW == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit reads(input logic [AW-1:0] dst);
      return dst != 0 && (dst == rsD || dst == rtD);
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      bit   lu, br, dstall;
      e = '0;
      if (!resetn) return e;
      e.fad  = near_d(rsD);
      e.fbd  = near_d(rtD);
      e.fae  = near_e(rsE);
      e.fbe  = near_e(rtE);
      lu     = memtoregE && reads(writeregE);
      br     = (branchD || jrD) && ((memtoregE && reads(writeregE)) ||
               (memtoregM && reads(writeregM)) || (!E2D && regwriteE && reads(writeregE)));
      e.start = (div_phase < 0) && divE && !d_stallM && !excM;
      e.done  = (div_phase == NDIV + 1);
      dstall  = ((div_phase < 0) && divE) || (div_phase >= 1 && div_phase <= NDIV);
      e.pcsel = (excM || pend) && !i_stallF;
      if (excM) begin
         e.flush = 4'b1111; e.stall = {i_stallF, 3'b000};
      end else if (d_stallM) begin
         e.stall = 4'b1111; e.flush = 4'b0001;
      end else if (dstall) begin
         e.stall = 4'b1110; e.flush = 4'b0010;
      end else if (lu || br) begin
         e.stall = 4'b1100; e.flush = 4'b0100;
      end else if (i_stallF) begin
         e.stall = 4'b1000; e.flush = 4'b1000;
      end
      if (pend && i_stallF) begin
         e.stall[3] = 1'b1; e.flush[3] = 1'b1;
      end
      return e;
   endfunction

   // State advance at the clock edge, using the inputs of the ending cycle
   task automatic model_step();
      if (!resetn) begin
         div_phase = -1; pend = 1'b0;
      end else begin
         if (div_phase < 0) begin
            if (divE && !d_stallM && !excM) div_phase = 1;
         end else if (div_phase <= NDIV) begin
            div_phase = excM ? -1 : div_phase + 1;
         end else begin
            div_phase = -1;
         end
         pend = i_stallF ? (pend || excM) : 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic push();
      exp_q.push_back(model_out());
   endtask

   task automatic assert_reset();
      resetn = 1'b0; div_phase = -1; pend = 1'b0;
   endtask

   task automatic idle_inputs();
      {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
      {branchD, jrD, regwriteE, memtoregE, divE} = 5'b00000;
      {regwriteM, memtoregM, regwriteW, i_stallF, d_stallM, excM} = 6'b000000;
   endtask

   task automatic rand_inputs();
      rsD = AW'($urandom_range(0, 3)); rtD = AW'($urandom_range(0, 3));
      rsE = AW'($urandom_range(0, 3)); rtE = AW'($urandom_range(0, 3));
      writeregE = AW'($urandom_range(0, 3));
      writeregM = AW'($urandom_range(0, 3));
      writeregW = AW'($urandom_range(0, 3));
      branchD   = ($urandom_range(0, 3) == 0);
      jrD       = ($urandom_range(0, 7) == 0);
      regwriteE = ($urandom_range(0, 1) == 0);
      memtoregE = ($urandom_range(0, 3) == 0);
      divE      = ($urandom_range(0, 5) == 0);
      regwriteM = ($urandom_range(0, 1) == 0);
      memtoregM = ($urandom_range(0, 3) == 0);
      regwriteW = ($urandom_range(0, 1) == 0);
      i_stallF  = ($urandom_range(0, 3) == 0);
      d_stallM  = ($urandom_range(0, 7) == 0);
      excM      = ($urandom_range(0, 15) == 0);
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: outputs are valid every cycle, compared mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("fwdD",  8'({forwardaD, forwardbD}), 8'({e.fad, e.fbd}));
            chk("fwdE",  8'({forwardaE, forwardbE}), 8'({e.fae, e.fbe}));
            chk("stall", 8'({stallF, stallD, stallE, stallM}), 8'(e.stall));
            chk("flush", 8'({flushD, flushE, flushM, flushW}), 8'(e.flush));
            chk("div",   8'({div_startE, div_doneE}), 8'({e.start, e.done}));
            chk("pcsel", 8'(pc_exc_selF), 8'(e.pcsel));
         end
      end
   end

   // Stimulus
   initial begin
      idle_inputs();
      assert_reset();
      repeat (3) begin tick(); push(); end
      tick(); resetn = 1'b1; push();
      // full divide followed by a back-to-back one
      for (int i = 0; i < 8; i++) begin tick(); idle_inputs(); divE = 1'b1; push(); end
      tick(); idle_inputs(); push();
      // add r3 in E, beq r3 in D
      tick(); regwriteE = 1'b1; writeregE = AW'(3); branchD = 1'b1; rsD = AW'(3); push();
      tick(); idle_inputs(); push();
      // lw r4 in E, consumer in D; next cycle the load sits in M
      tick(); memtoregE = 1'b1; regwriteE = 1'b1; writeregE = AW'(4); rsD = AW'(4); push();
      tick(); idle_inputs(); memtoregM = 1'b1; regwriteM = 1'b1; writeregM = AW'(4);
      rsE = AW'(4); push();
      // data SRAM stall for three cycles
      for (int i = 0; i < 3; i++) begin tick(); idle_inputs(); d_stallM = 1'b1; push(); end
      // exception during a two-cycle fetch stall
      tick(); idle_inputs(); excM = 1'b1; i_stallF = 1'b1; push();
      tick(); excM = 1'b0; push();
      tick(); i_stallF = 1'b0; push();
      tick(); push();
      // random traffic with occasional asynchronous resets
      for (int i = 0; i < NCYC; i++) begin
         tick();
         rand_inputs();
         resetn = 1'b1;
         if ($urandom_range(0, 199) == 0) assert_reset();
         push();
      end
      // reset in BUSY with cnt=2 aborts the divide
      tick(); idle_inputs(); resetn = 1'b1; push();
      tick(); divE = 1'b1; push();
      for (int i = 0; i < 2; i++) begin tick(); push(); end
      tick(); assert_reset(); push();
      tick(); push();
      tick(); resetn = 1'b1; divE = 1'b0; push();
      for (int i = 0; i < 8; i++) begin tick(); push(); end
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and pipeline-control unit for the five-stage MIPS core. It resolves GPR forwarding for the decode-stage branch comparator and the execute-stage ALU, and detects load-use and branch hazards. It also owns three sequential controls: the fixed-latency divider handshake, stalls for variable-latency SRAM ports, and exception redirect. It drives every per-stage stall and flush in the datapath.

## Interface
Parameters:
- REG_AW, 5: GPR address width.
- DIV_CYCLES, 32: divider busy cycles, valid range 2..63.

Ports:
- clk  in  1  core clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- rsD, rtD  in  REG_AW  decode source regs.
- branchD, jrD  in  1  decode compare-branch / register jump.
- rsE, rtE, writeregE  in  REG_AW  execute regs.
- regwriteE, memtoregE, divE  in  1  execute controls; divE marks div/divu.
- writeregM, writeregW  in  REG_AW  destinations.
- regwriteM, memtoregM, regwriteW  in  1  controls.
- i_stallF  in  1  instruction SRAM not ready.
- d_stallM  in  1  data SRAM not ready.
- excM  in  1  exception/eret committed in M.
- forwardaD, forwardbD  out  2  00 regfile, 01 E result, 10 M, 11 W.
- forwardaE, forwardbE  out  2  00 regfile, 01 W, 10 M.
- stallF, stallD, stallE, stallM  out  1  hold stage register.
- flushD, flushE, flushM, flushW  out  1  bubble into stage register.
- div_startE  out  1  one-cycle divider start.
- div_doneE  out  1  divider result valid, latch HI/LO.
- pc_exc_selF  out  1  select exception vector into PC.

## Operation
- Reg 0 never matches in any comparison.
- Forwarding priority is nearest stage: E over M over W for D; M over W for E.
- Load-use: luD = memtoregE & writeregE matches rsD or rtD. Uses writeregE, not rtE.
- Branch: brD = (branchD|jrD) & hazard. Hazard = (memtoregE|memtoregM) producer match, plus regwriteE match when HAZ_FWD_E2D_EN is off.
- Divider FSM states:
  - IDLE: if divE & !d_stallM & !excM, pulse div_startE and go to BUSY with cnt=0.
  - BUSY: cnt increments each cycle. At cnt==DIV_CYCLES-1 go to DONE.
  - DONE: assert div_doneE, go to IDLE.
  - excM in IDLE or BUSY returns the FSM to IDLE and suppresses div_doneE.
- divstall = (IDLE & divE) | BUSY.
- Exception pending flag exc_pend:
  - Set by excM while i_stallF=1.
  - Cleared when i_stallF=0.
  - pc_exc_selF = (excM & !i_stallF) | (exc_pend & !i_stallF).
- Output priority, first match wins:
  1. excM: flushD, flushE, flushM, flushW = 1; all stalls 0 except stallF = i_stallF.
  2. d_stallM: stallF, stallD, stallE, stallM = 1; flushW = 1.
  3. divstall: stallF, stallD, stallE = 1; flushM = 1.
  4. luD|brD: stallF, stallD = 1; flushE = 1.
  5. i_stallF: stallF = 1; flushD = 1.
- exc_pend with i_stallF=1 holds stallF=1 and flushD=1.

## Timing
- All outputs 0 in reset. The FSM resets to IDLE, with cnt=0 and exc_pend=0.
- Forward, stall and flush outputs are combinational from current inputs and registered state. No added latency.
- A div instruction occupies E for DIV_CYCLES+2 cycles:
  - 1 IDLE cycle with div_startE.
  - DIV_CYCLES BUSY cycles.
  - 1 DONE cycle, after which E advances.
- Back-to-back divs: the second starts in the cycle after DONE.
- Reset asserted mid-divide aborts immediately with no div_doneE.
- excM in the same cycle as d_stallM: the exception wins. The data request is killed by flushW.

## Configuration
- HAZ_FWD_E2D_EN defined: E-stage ALU result is forwarded to D (code 01). Branch waits only on loads in E or M.
- HAZ_FWD_E2D_EN undefined: forwardaD/forwardbD never produce 01. Any regwriteE match on a branch/jr source stalls D for one cycle.

## Structure
- Shared package pipe_pkg holds:
  - FWD_* 2-bit encodings.
  - Divider state encodings.
  - REG_AW default.
- One sub-module, haz_div_fsm: FSM plus counter. It outputs divstall, div_startE and div_doneE.

## Test plan
- Add r3 in E, beq r3 in D, macro on: forwardaD=01, no stall. Macro off: stallD=1 and flushE=1 for exactly 1 cycle.
- lw r4 in E, add using r4 in D: stallF=stallD=flushE=1 for one cycle. Next cycle forwardaE=10 from M.
- div with DIV_CYCLES=4: div_startE at t0, BUSY t1–t4, div_doneE at t5, stallE released at t5. E occupancy is 6 cycles.
- d_stallM high 3 cycles: stallF..stallM=1 and flushW=1 for 3 cycles. Pipeline resumes unchanged.
- excM with i_stallF high 2 cycles: flushD..W=1 at t0. pc_exc_selF=1 at t2 only.
- resetn low at BUSY cnt=2: all outputs 0 asynchronously. div_doneE is never asserted.
